bht_update_ctrl: RTL
====================

Name: bht_update_ctrl

Overview:
- Sequences all accesses to the 8-entry 2-bit branch history table (BHT).
- Resolved-branch updates from the pipeline are buffered in a small FIFO and applied to the table one per cycle when fetch is not looking up.
- Fetch lookups normally win the table. Updates are forced in, with fetch stalled, when the FIFO is full or the head update has waited STARVE_LIMIT cycles.

Parameters:
- DEPTH, 4, update FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, cycles head entry may wait before it is forced (>=1)
- IDX_W, 3, table index width; index = pc[IDX_W:1] (word-aligned PCs)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch stage requests a prediction this cycle
- fetch_pc  in  16  PC of the fetched instruction
- fetch_grant  out  1  lookup is on the table this cycle; pred_taken valid
- fetch_stall  out  1  fetch_req high but table taken by a forced update
- pred_taken  out  1  prediction = tbl_predict when fetch_grant, else 0
- upd_valid  in  1  resolved branch presented
- upd_pc  in  16  PC of resolved branch
- upd_taken  in  1  actual outcome, 1 = taken
- upd_ready  out  1  FIFO can accept; transfer = upd_valid & upd_ready
- tbl_idx  out  IDX_W  table index driven this cycle
- tbl_load  out  1  one-cycle update strobe to table
- tbl_branched  out  1  outcome bit for the update
- tbl_predict  in  1  table's prediction for tbl_idx
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Reset (reset_n low, asynchronous): FIFO emptied (queued updates discarded), age=0, state=IDLE. All outputs 0, including upd_ready. upd_ready rises in the first cycle after release.
- FIFO: stores {idx = upd_pc[IDX_W:1], taken}. upd_ready = (count < DEPTH), from the registered count. No same-cycle pass-through when full.
- Push and pop in the same cycle: count unchanged, order preserved. Pointers wrap modulo DEPTH.
- Enqueue latency: an entry pushed at edge N may drive tbl_load no earlier than cycle N+1.
- State register (next state computed from next count/age):
  - IDLE: count==0.
  - PEND: count>0, age<STARVE_LIMIT, count<DEPTH.
  - FORCE: count>0 and (count==DEPTH or age>=STARVE_LIMIT).
- Per-cycle arbitration, by state:
  - IDLE: tbl_idx=fetch_pc[IDX_W:1]; fetch_grant=fetch_req; tbl_load=0.
  - PEND with fetch_req=1: fetch granted, no pop, age += 1.
  - PEND with fetch_req=0: pop head; tbl_idx=head.idx, tbl_load=1, tbl_branched=head.taken.
  - FORCE: pop head as above; fetch_grant=0; fetch_stall=fetch_req.
  - After a FORCE pop: next state is PEND or IDLE per the next count/age, unless the FIFO is still full (stay FORCE).
- Age counter: counts cycles the current head has waited un-popped. Cleared on every pop and whenever the FIFO is empty. Saturates at STARVE_LIMIT.
- At most one tbl_load per cycle. Updates reach the table in arrival order.
- tbl_idx = 0 when neither fetch nor update owns the table.
- Lookups read the table as-is. Queued updates to the same index are not forwarded; a stale prediction is acceptable.
- fetch_stall and fetch_grant are never both 1. tbl_load and fetch_grant are never both 1.

Test Plan:
- Reset, then a single push with upd_pc=0x0006, upd_taken=1, fetch_req=0 -> next cycle tbl_load=1, tbl_idx=3, tbl_branched=1; occupancy 1->0.
- fetch_req held 1 and one update pushed -> fetch_grant=1 for 8 cycles. Then 1 cycle with fetch_stall=1, tbl_load=1. Then fetch_grant resumes.
- 4 back-to-back pushes with fetch_req=1 -> upd_ready=0 when occupancy=4. Next cycle is FORCE: pops in push order with fetch_stall=1. upd_ready=1 the cycle after count<4.
- Simultaneous push and pop at occupancy 2 -> occupancy stays 2; the popped entry is the oldest.
- reset_n pulsed low mid-cycle with 3 entries queued -> all outputs 0 immediately, occupancy=0, no tbl_load after release.
- fetch_req=1 with fetch_pc=0x000E and tbl_predict=1 in IDLE -> tbl_idx=7, fetch_grant=1, pred_taken=1, tbl_load=0.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: arbitrates the 8-entry 2-bit branch history table between
// fetch-stage lookups and queued resolved-branch updates. Updates wait in a
// small FIFO and slip in on cycles fetch leaves idle; when the FIFO fills or
// the head entry has waited too long, the update is forced and fetch stalls.
module bht_update_ctrl #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int IDX_W        = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fetch_req,
  input  logic [15:0]                fetch_pc,
  output logic                       fetch_grant,
  output logic                       fetch_stall,
  output logic                       pred_taken,
  input  logic                       upd_valid,
  input  logic [15:0]                upd_pc,
  input  logic                       upd_taken,
  output logic                       upd_ready,
  output logic [IDX_W-1:0]           tbl_idx,
  output logic                       tbl_load,
  output logic                       tbl_branched,
  input  logic                       tbl_predict,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_entry_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  upd_entry_t       mem_q [DEPTH];
  upd_entry_t       mem_d [DEPTH];
  logic             out_en_q, out_en_d;

  logic             full;
  logic             ready_int;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] fetch_idx;
  upd_entry_t       head;

  // PC bits outside the index field carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[15:IDX_W+1], fetch_pc[0],
                            upd_pc[15:IDX_W+1], upd_pc[0]};

  assign fetch_idx = fetch_pc[IDX_W:1];
  assign head      = mem_q[rd_ptr_q];

  // FIFO handshake, pop decision, and next count/age/state derived from them.
  always_comb begin
    full      = (count_q == FULL_CNT);
    ready_int = out_en_q & ~full;
    push      = upd_valid & ready_int;
    pop       = (state_q == FORCE) | ((state_q == PEND) & ~fetch_req);

    out_en_d  = 1'b1;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{idx: upd_pc[IDX_W:1], taken: upd_taken};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A fresh head (after a pop, or arriving into an empty FIFO) starts at 0.
    if (pop || (count_q == '0)) begin
      age_d = '0;
    end else if (age_q < AGE_MAX) begin
      age_d = age_q + AGE_W'(1);
    end else begin
      age_d = age_q;
    end

    if (count_d == '0) begin
      state_d = IDLE;
    end else if ((count_d == FULL_CNT) || (age_d >= AGE_MAX)) begin
      state_d = FORCE;
    end else begin
      state_d = PEND;
    end
  end

  // Table ownership for the current cycle; everything is held at 0 until the
  // first clock edge after reset release.
  always_comb begin
    fetch_grant  = 1'b0;
    fetch_stall  = 1'b0;
    tbl_load     = 1'b0;
    tbl_branched = 1'b0;
    tbl_idx      = '0;
    if (out_en_q) begin
      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            fetch_grant = 1'b1;
            tbl_idx     = fetch_idx;
          end
        end
        PEND: begin
          if (fetch_req) begin
            fetch_grant = 1'b1;
            tbl_idx     = fetch_idx;
          end else begin
            tbl_load     = 1'b1;
            tbl_idx      = head.idx;
            tbl_branched = head.taken;
          end
        end
        FORCE: begin
          fetch_stall  = fetch_req;
          tbl_load     = 1'b1;
          tbl_idx      = head.idx;
          tbl_branched = head.taken;
        end
        default: begin
          fetch_grant = 1'b0;
        end
      endcase
    end
    pred_taken = fetch_grant & tbl_predict;
    upd_ready  = ready_int;
    occupancy  = count_q;
  end

  // State, FIFO storage and bookkeeping registers; reset discards queued work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      age_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      age_q    <= age_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      out_en_q <= out_en_d;
    end
  end

endmodule
